// File: rtl/router_input_buffer.sv
// router_input_buffer
//   Per-direction ingress stage in front of the router. It terminates the
//   inter-core 4-phase req/ack link and queues packets in a small FIFO. The
//   head of the queue is presented to the router, which pops it with rtr_ack.
//   When the queue is full, the upstream sender stalls.
//
// Optional feature: define ROUTER_IBUF_STATS_EN to add the pkt_in_cnt and
//   stall_cnt statistics outputs (16-bit counters that saturate).
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active low
//   link_req     in   upstream request, held with link_packet until link_ack
//   link_packet  in   upstream packet ([33:31] route, [30:0] payload)
//   link_ack     out  one-cycle pulse: packet captured
//   rtr_valid    out  queue non-empty
//   rtr_packet   out  head entry, zero when empty
//   rtr_ack      in   router pop, ignored when empty
//   full         out  count == DEPTH
//   count        out  current occupancy
//   pkt_in_cnt   out  (stats) captures since reset
//   stall_cnt    out  (stats) cycles idle with req pending while full
module router_input_buffer #(
  parameter int PKT_W = 34,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   link_req,
  input  logic [PKT_W-1:0]       link_packet,
  output logic                   link_ack,
  output logic                   rtr_valid,
  output logic [PKT_W-1:0]       rtr_packet,
  input  logic                   rtr_ack,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
`ifdef ROUTER_IBUF_STATS_EN
  ,
  output logic [15:0]            pkt_in_cnt,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACK      = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  logic [1:0]       state;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // full comes straight from the count register, so a pop in the same cycle
  // cannot open a slot for a push until the next cycle.
  assign full       = (count == (AW+1)'(DEPTH));
  assign rtr_valid  = (count != '0);
  assign rtr_packet = rtr_valid ? mem[rd_ptr] : '0;
  assign push       = (state == IDLE) && link_req && !full;
  assign pop        = rtr_valid && rtr_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      link_ack <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      // The ack register is set by the capture, so it is high for exactly
      // the one cycle that the FSM spends in ACK.
      link_ack <= push;
      case (state)
        IDLE:     if (push) state <= ACK;
        ACK:      state <= WAIT_LOW;
        // A req that is still high here is the same packet, so it is not captured again.
        WAIT_LOW: if (!link_req) state <= IDLE;
        default:  state <= IDLE;
      endcase
      if (push) begin
        mem[wr_ptr] <= link_packet;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ROUTER_IBUF_STATS_EN
  logic stall;
  assign stall = (state == IDLE) && link_req && full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_in_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (push && pkt_in_cnt != 16'hFFFF) pkt_in_cnt <= pkt_in_cnt + 1'b1;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
